// File: rtl/hist_pkg.sv
// Shared state encoding and default sizing for the sample histogram block.
package hist_pkg;

   localparam int HIST_BIN_BITS    = 8;
   localparam int HIST_COUNT_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACQUIRE,
      ST_DRAIN,
      ST_DONE
   } hist_state_e;

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port bin storage: one write port, one read port, registered read (read-first).
module hist_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/sample_histogram.sv
// Histogram of signed samples into 2^BIN_BITS bins, sequenced IDLE -> CLEAR -> ACQUIRE -> DRAIN -> DONE.
// Define HIST_SATURATE_EN to make bins saturate and raise overflow_o instead of wrapping.
module sample_histogram
   import hist_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int BIN_BITS    = HIST_BIN_BITS,
   parameter int COUNT_WIDTH = HIST_COUNT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   valid_i,
   input  logic                   start_i,
   input  logic [31:0]            n_samples_i,
   input  logic                   rd_en_i,
   input  logic [BIN_BITS-1:0]    rd_addr_i,
   output logic [COUNT_WIDTH-1:0] rd_data_o,
   output logic                   rd_valid_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   overflow_o,
   output hist_state_e            state_o
);

   // Handshakes: valid_i qualifies data_i for one cycle with no backpressure and is only
   // taken in ACQUIRE; rd_en_i (honoured in IDLE/DONE) returns rd_valid_o/rd_data_o one cycle later.

   localparam logic [BIN_BITS-1:0] BIN_MSB  = BIN_BITS'(1) << (BIN_BITS - 1);
   localparam logic [BIN_BITS-1:0] BIN_LAST = '1;

   hist_state_e            state_q, state_d;
   logic [31:0]            n_q, n_d, cnt_q, cnt_d;
   logic [BIN_BITS-1:0]    clr_addr_q, clr_addr_d;
   logic                   drain_q, drain_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   s1_valid_q, s1_valid_d;
   logic [BIN_BITS-1:0]    s1_addr_q, s1_addr_d;
   logic                   lw_valid_q, lw_valid_d;
   logic [BIN_BITS-1:0]    lw_addr_q, lw_addr_d;
   logic [COUNT_WIDTH-1:0] lw_data_q, lw_data_d;

   logic                   accept, rd_ok, ram_we, unused_data;
   logic [BIN_BITS-1:0]    sample_bin, ram_raddr, ram_waddr;
   logic [COUNT_WIDTH-1:0] ram_wdata, ram_rdata, base, incr;

   assign sample_bin  = data_i[WIDTH-1 -: BIN_BITS] ^ BIN_MSB;
   assign accept      = (state_q == ST_ACQUIRE) && valid_i;
   assign rd_ok       = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign unused_data = ^data_i;

   // The RAM read of a sample races the write of the previous sample to the same bin;
   // the last written value is forwarded in that case.
   always_comb begin
      base = (lw_valid_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : ram_rdata;
`ifdef HIST_SATURATE_EN
      incr = (&base) ? base : base + COUNT_WIDTH'(1);
`else
      incr = base + COUNT_WIDTH'(1);
`endif
   end

   always_comb begin
      ram_we    = s1_valid_q;
      ram_waddr = s1_addr_q;
      ram_wdata = incr;
      if (state_q == ST_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr_q;
         ram_wdata = '0;
      end
   end

   assign ram_raddr = (state_q == ST_ACQUIRE) ? sample_bin : rd_addr_i;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      clr_addr_d = clr_addr_q;
      drain_d    = drain_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d    = ST_CLEAR;
               n_d        = n_samples_i;
               cnt_d      = '0;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + BIN_BITS'(1);
            if (clr_addr_q == BIN_LAST) begin
               state_d = (n_q == '0) ? ST_DRAIN : ST_ACQUIRE;
               drain_d = 1'b0;
            end
         end
         ST_ACQUIRE: begin
            if (accept) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_q + 32'd1 == n_q) begin
                  state_d = ST_DRAIN;
                  drain_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_valid_d = rd_en_i && rd_ok;
      s1_valid_d = accept;
      s1_addr_d  = sample_bin;
      lw_valid_d = s1_valid_q;
      lw_addr_d  = s1_addr_q;
      lw_data_d  = incr;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         cnt_q      <= '0;
         clr_addr_q <= '0;
         drain_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         lw_valid_q <= 1'b0;
         lw_addr_q  <= '0;
         lw_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         clr_addr_q <= clr_addr_d;
         drain_q    <= drain_d;
         rd_valid_q <= rd_valid_d;
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         lw_valid_q <= lw_valid_d;
         lw_addr_q  <= lw_addr_d;
         lw_data_q  <= lw_data_d;
      end
   end

`ifdef HIST_SATURATE_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (s1_valid_q && (&base)) ovf_d = 1'b1;
      if (rd_ok && start_i) ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign overflow_o = ovf_q;
`else
   assign overflow_o = 1'b0;
`endif

   hist_ram #(
      .ADDR_W (BIN_BITS),
      .DATA_W (COUNT_WIDTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign busy_o     = (state_q == ST_CLEAR) || (state_q == ST_ACQUIRE) || (state_q == ST_DRAIN);
   assign done_o     = (state_q == ST_DONE);
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_valid_q ? ram_rdata : '0;
   assign state_o    = state_q;

endmodule
